// File: rtl/c4_pkg.sv
// Shared constants for the Connect4 win detector: game status codes, scan FSM states
// and the fixed line numbering of the 4x4 board.
package c4_pkg;

  localparam int BOARD_N    = 4;
  localparam int NUM_CELLS  = BOARD_N * BOARD_N;
  localparam int NUM_LINES  = 2 * BOARD_N + 2;
  localparam int LINE_IDX_W = 4;

  // Rows come first, then columns, then the two diagonals
  localparam int LINE_ROW_BASE = 0;
  localparam int LINE_COL_BASE = BOARD_N;
  localparam int LINE_DIAG     = 2 * BOARD_N;
  localparam int LINE_ANTI     = 2 * BOARD_N + 1;

  localparam logic [1:0] GS_PLAYING = 2'b00;
  localparam logic [1:0] GS_P1_WIN  = 2'b01;
  localparam logic [1:0] GS_P2_WIN  = 2'b10;
  localparam logic [1:0] GS_DRAW    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/c4_line_mask.sv
// Combinational map from a line index to the set of board cells on that line.
// Indices past the last diagonal give an empty mask.
module c4_line_mask #(
  parameter int BOARD_N = 4,
  parameter int CELLS   = BOARD_N * BOARD_N,
  parameter int LINE_W  = $clog2(2 * BOARD_N + 2)
) (
  input  logic [LINE_W-1:0] line_idx,
  output logic [CELLS-1:0]  cell_mask
);

  always_comb begin
    int idx;
    int pos;
    cell_mask = '0;
    idx = int'(line_idx);
    for (int k = 0; k < BOARD_N; k++) begin
      pos = -1;
      if (idx < BOARD_N) begin
        pos = idx * BOARD_N + k;
      end else if (idx < 2 * BOARD_N) begin
        pos = k * BOARD_N + (idx - BOARD_N);
      end else if (idx == 2 * BOARD_N) begin
        pos = k * (BOARD_N + 1);
      end else if (idx == 2 * BOARD_N + 1) begin
        // anti-diagonal cell k sits at row k, column N-1-k
        pos = (k + 1) * (BOARD_N - 1);
      end
      if (pos >= 0) begin
        cell_mask = cell_mask | (CELLS'(1) << pos);
      end
    end
  end

endmodule

// File: rtl/c4_win_detector.sv
// Sequential Connect4 win detector: snapshots the board on in_start, checks one line per cycle
// and reports a sticky game status. Define WINLINE_MASK_EN to expose the winning cell mask.
module c4_win_detector
  import c4_pkg::*;
#(
  parameter int BOARD_N = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [BOARD_N*BOARD_N-1:0]           in_gameboard,
  input  logic [BOARD_N*BOARD_N-1:0]           in_players_cells,
  input  logic                                 in_start,
  output logic [1:0]                           out_game_status,
  output logic                                 out_busy,
  output logic                                 out_done,
  output logic [$clog2(2*BOARD_N+2)-1:0]       out_win_line
`ifdef WINLINE_MASK_EN
  ,
  output logic [BOARD_N*BOARD_N-1:0]           out_win_mask
`endif
);

  localparam int CELLS  = BOARD_N * BOARD_N;
  localparam int LINE_W = $clog2(2 * BOARD_N + 2);
  localparam logic [LINE_W-1:0] LAST_LINE  = LINE_W'(2 * BOARD_N + 1);
  localparam logic [CELLS-1:0]  FULL_BOARD = '1;

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  cnt_q, cnt_d;
  logic [CELLS-1:0]   board_q, board_d;
  logic [CELLS-1:0]   players_q, players_d;
  logic [1:0]         status_q, status_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LINE_W-1:0]  win_line_q, win_line_d;
`ifdef WINLINE_MASK_EN
  logic [CELLS-1:0]   win_mask_q, win_mask_d;
`endif

  logic [CELLS-1:0]   line_sel;
  logic               line_full;
  logic               line_p1;
  logic               line_p2;

  c4_line_mask #(
    .BOARD_N (BOARD_N),
    .CELLS   (CELLS),
    .LINE_W  (LINE_W)
  ) u_line_mask (
    .line_idx  (cnt_q),
    .cell_mask (line_sel)
  );

  assign line_full = ((board_q & line_sel) == line_sel);
  assign line_p1   = ((players_q & line_sel) == '0);
  assign line_p2   = ((players_q & line_sel) == line_sel);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    board_d    = board_q;
    players_d  = players_q;
    status_d   = status_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    win_line_d = win_line_q;
`ifdef WINLINE_MASK_EN
    win_mask_d = win_mask_q;
`endif
    case (state_q)
      IDLE: begin
        // A decided game never rescans
        if (in_start && (status_q == GS_PLAYING)) begin
          board_d   = in_gameboard;
          players_d = in_players_cells;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (line_full && (line_p1 || line_p2)) begin
          status_d   = line_p1 ? GS_P1_WIN : GS_P2_WIN;
          win_line_d = cnt_q;
`ifdef WINLINE_MASK_EN
          win_mask_d = line_sel;
`endif
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = DONE;
        end else if (cnt_q == LAST_LINE) begin
          status_d = (board_q == FULL_BOARD) ? GS_DRAW : GS_PLAYING;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      board_q    <= '0;
      players_q  <= '0;
      status_q   <= GS_PLAYING;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      win_line_q <= '0;
`ifdef WINLINE_MASK_EN
      win_mask_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      board_q    <= board_d;
      players_q  <= players_d;
      status_q   <= status_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      win_line_q <= win_line_d;
`ifdef WINLINE_MASK_EN
      win_mask_q <= win_mask_d;
`endif
    end
  end

  assign out_game_status = status_q;
  assign out_busy        = busy_q;
  assign out_done        = done_q;
  assign out_win_line    = win_line_q;
`ifdef WINLINE_MASK_EN
  assign out_win_mask    = win_mask_q;
`endif

endmodule
